// File: rtl/gcd_sweep_pkg.sv
// Shared definitions for the GCD sweep driver: state encoding, counter width
// and the saturating counter helper.
package gcd_sweep_pkg;

    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_SUB  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_ACK       = 3'd5;
    localparam logic [2:0] ST_NEXT      = 3'd6;
    localparam logic [2:0] ST_FIN       = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD      = ST_LOAD,
        S_START     = ST_START,
        S_WAIT_SUB  = ST_WAIT_SUB,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_ACK       = ST_ACK,
        S_NEXT      = ST_NEXT,
        S_FIN       = ST_FIN
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/gcd_sweep_driver_if.sv
// Handshake and operand bus between the sweep driver (master) and a GCD core (slave).
interface gcd_sweep_driver_if;
    logic       Start;
    logic       Ack;
    logic [7:0] Ain;
    logic [7:0] Bin;
    logic       q_Sub;
    logic       q_Done;
    logic [7:0] AB_GCD;

    modport master (output Start, Ack, Ain, Bin, input q_Sub, q_Done, AB_GCD);
    modport slave  (input Start, Ack, Ain, Bin, output q_Sub, q_Done, AB_GCD);
endinterface

// File: rtl/gcd_sweep_driver_op_stepper.sv
// Operand pair registers for the sweep: loads both operands with the low bound
// and walks Bin fastest, then Ain, comparing before incrementing so 255 never wraps.
module gcd_op_stepper (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] load_val,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    output logic [7:0] ain,
    output logic [7:0] bin,
    output logic       last_pair
);
    logic [7:0] ain_d, ain_q;
    logic [7:0] bin_d, bin_q;

    // Next operand pair selection
    always_comb begin
        ain_d = ain_q;
        bin_d = bin_q;
        if (load) begin
            ain_d = load_val;
            bin_d = load_val;
        end else if (step) begin
            if (bin_q < hi) begin
                bin_d = bin_q + 8'd1;
            end else if (ain_q < hi) begin
                ain_d = ain_q + 8'd1;
                bin_d = lo;
            end else begin
                ain_d = ain_q;
                bin_d = bin_q;
            end
        end else begin
            ain_d = ain_q;
            bin_d = bin_q;
        end
    end

    // Operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ain_q <= 8'h00;
            bin_q <= 8'h00;
        end else if (cen) begin
            ain_q <= ain_d;
            bin_q <= bin_d;
        end
    end

    assign ain       = ain_q;
    assign bin       = bin_q;
    assign last_pair = (bin_q >= hi) && (ain_q >= hi);
endmodule

// File: rtl/gcd_sweep_driver.sv
// Sweeps every (Ain, Bin) pair in [Lo, Hi] x [Lo, Hi] through an external GCD
// core, recording each result with its WAIT_DONE cycle count.
module gcd_sweep_driver
    import gcd_sweep_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Go,
    input  logic [7:0]       Lo,
    input  logic [7:0]       Hi,
    gcd_sweep_driver_if.master core,
    output logic             Res_Valid,
    output logic [7:0]       Res_A,
    output logic [7:0]       Res_B,
    output logic [7:0]       Res_GCD,
    output logic [CNT_W-1:0] Res_Clocks,
    output logic             Busy,
    output logic             Sweep_Done,
    output logic             Err
);
    localparam logic [CNT_W-1:0] TMO_LIM = TIMEOUT[CNT_W-1:0];

    state_e           state_d, state_q;
    logic [7:0]       lo_d, lo_q, hi_d, hi_q;
    logic [CNT_W-1:0] cnt_d, cnt_q, tmo_d, tmo_q;
    logic [7:0]       res_a_d, res_a_q, res_b_d, res_b_q, res_gcd_d, res_gcd_q;
    logic [CNT_W-1:0] res_clk_d, res_clk_q;
    logic             sweep_done_d, sweep_done_q, err_d, err_q;
    logic             start_q, ack_q, res_valid_q, busy_q;
    logic             load_s, step_s, last_s;
    logic [7:0]       ain_s, bin_s;

    gcd_op_stepper u_stepper (
        .clk       (Clk),
        .rst_n     (Reset),
        .cen       (CEN),
        .load      (load_s),
        .step      (step_s),
        .load_val  (Lo),
        .lo        (lo_q),
        .hi        (hi_q),
        .ain       (ain_s),
        .bin       (bin_s),
        .last_pair (last_s)
    );

    // Sweep sequencing, cycle/timeout counting and result capture
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        res_a_d      = res_a_q;
        res_b_d      = res_b_q;
        res_gcd_d    = res_gcd_q;
        res_clk_d    = res_clk_q;
        sweep_done_d = sweep_done_q;
        err_d        = err_q;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    lo_d         = Lo;
                    hi_d         = Hi;
                    load_s       = 1'b1;
                    sweep_done_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = (Lo > Hi) ? S_FIN : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: begin
                tmo_d   = {CNT_W{1'b0}};
                state_d = S_WAIT_SUB;
            end
            S_WAIT_SUB: begin
                cnt_d = {CNT_W{1'b0}};
                tmo_d = sat_inc(tmo_q);
                if (core.q_Sub) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q >= TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_WAIT_SUB;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = sat_inc(cnt_q);
                tmo_d = sat_inc(tmo_q);
                if (core.q_Done) begin
                    res_a_d   = ain_s;
                    res_b_d   = bin_s;
                    res_gcd_d = core.AB_GCD;
                    res_clk_d = sat_inc(cnt_q);
                    state_d   = S_ACK;
                end else if (tmo_q >= TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_ACK:  state_d = S_NEXT;
            S_NEXT: begin
                if (last_s) begin
                    state_d = S_FIN;
                end else begin
                    step_s  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_FIN) begin
            sweep_done_d = 1'b1;
        end else begin
            sweep_done_d = sweep_done_d;
        end
    end

    // State, record and registered-output flops; everything freezes while CEN=0
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            lo_q         <= 8'h00;
            hi_q         <= 8'h00;
            cnt_q        <= {CNT_W{1'b0}};
            tmo_q        <= {CNT_W{1'b0}};
            res_a_q      <= 8'h00;
            res_b_q      <= 8'h00;
            res_gcd_q    <= 8'h00;
            res_clk_q    <= {CNT_W{1'b0}};
            sweep_done_q <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            ack_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else if (CEN) begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            res_a_q      <= res_a_d;
            res_b_q      <= res_b_d;
            res_gcd_q    <= res_gcd_d;
            res_clk_q    <= res_clk_d;
            sweep_done_q <= sweep_done_d;
            err_q        <= err_d;
            start_q      <= (state_d == S_START);
            ack_q        <= (state_d == S_ACK);
            res_valid_q  <= (state_d == S_ACK);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_FIN);
        end
    end

    assign core.Start = start_q;
    assign core.Ack   = ack_q;
    assign core.Ain   = ain_s;
    assign core.Bin   = bin_s;
    assign Res_Valid  = res_valid_q;
    assign Res_A      = res_a_q;
    assign Res_B      = res_b_q;
    assign Res_GCD    = res_gcd_q;
    assign Res_Clocks = res_clk_q;
    assign Busy       = busy_q;
    assign Sweep_Done = sweep_done_q;
    assign Err        = err_q;
endmodule

// File: tb/tb_gcd_sweep_driver.sv
// Directed and randomized sweeps against a behavioural GCD core; results are
// checked against an arithmetic list of all (a, b, gcd) pairs in the sweep.
`timescale 1ns/1ps
module tb_gcd_sweep_driver;
    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        CEN   = 1'b0;
    logic        Go    = 1'b0;
    logic [7:0]  Lo    = 8'd0;
    logic [7:0]  Hi    = 8'd0;
    logic        Res_Valid, Busy, Sweep_Done, Err;
    logic [7:0]  Res_A, Res_B, Res_GCD;
    logic [15:0] Res_Clocks;

    gcd_sweep_driver_if core_if ();

    gcd_sweep_driver #(.TIMEOUT(15)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CEN        (CEN),
        .Go         (Go),
        .Lo         (Lo),
        .Hi         (Hi),
        .core       (core_if),
        .Res_Valid  (Res_Valid),
        .Res_A      (Res_A),
        .Res_B      (Res_B),
        .Res_GCD    (Res_GCD),
        .Res_Clocks (Res_Clocks),
        .Busy       (Busy),
        .Sweep_Done (Sweep_Done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct { int a; int b; int g; int c; } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t got_q[$];
    int   n_start = 0;
    int   n_ack   = 0;
    bit   hang    = 1'b0;
    int   core_st;
    int   core_lat;

    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [7:0] gcd_sub(input logic [7:0] a, input logic [7:0] b);
        int x = int'(a);
        int y = int'(b);
        if (x == 0) return 8'(y);
        if (y == 0) return 8'(x);
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return 8'(x);
    endfunction

    function automatic int core_latency(input int a, input int b);
        return ((a + b) % 4) + 1;
    endfunction

    // Behavioural GCD core, clock-enabled like the driver
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            core_st        <= 0;
            core_lat       <= 0;
            core_if.q_Sub  <= 1'b0;
            core_if.q_Done <= 1'b0;
            core_if.AB_GCD <= 8'd0;
        end else if (CEN) begin
            case (core_st)
                0: if (core_if.Start) begin
                    core_st        <= 1;
                    core_if.q_Sub  <= 1'b1;
                    core_lat       <= core_latency(int'(core_if.Ain), int'(core_if.Bin));
                    core_if.AB_GCD <= gcd_sub(core_if.Ain, core_if.Bin);
                end
                1: if (!hang) begin
                    if (core_lat <= 1) begin
                        core_st        <= 2;
                        core_if.q_Sub  <= 1'b0;
                        core_if.q_Done <= 1'b1;
                    end else begin
                        core_lat <= core_lat - 1;
                    end
                end
                2: if (core_if.Ack) begin
                    core_st        <= 0;
                    core_if.q_Done <= 1'b0;
                end
                default: core_st <= 0;
            endcase
        end
    end

    // Record every enabled Start, Ack and result strobe
    always @(negedge Clk) begin
        if (Reset && CEN) begin
            if (Res_Valid) begin
                res_t r;
                r.a = int'(Res_A);
                r.b = int'(Res_B);
                r.g = int'(Res_GCD);
                r.c = int'(Res_Clocks);
                got_q.push_back(r);
            end
            if (core_if.Start) n_start++;
            if (core_if.Ack)   n_ack++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input int lo, input int hi, input bit tog, input string tag,
                             output int base, output int cyc);
        res_t exp_q[$];
        int   sb, ab;
        bit   done;
        base = got_q.size();
        sb   = n_start;
        ab   = n_ack;
        for (int a = lo; a <= hi; a++) begin
            for (int b = lo; b <= hi; b++) begin
                res_t r;
                r.a = a;
                r.b = b;
                r.g = gcd_ref(a, b);
                r.c = core_latency(a, b);
                exp_q.push_back(r);
            end
        end
        @(posedge Clk); #1;
        Lo  = lo[7:0];
        Hi  = hi[7:0];
        Go  = 1'b1;
        CEN = 1'b1;
        @(posedge Clk); #1;
        Go   = 1'b0;
        done = 1'b0;
        cyc  = -1;
        for (int i = 0; i < 3000; i++) begin
            if (Sweep_Done) begin
                done = 1'b1;
                cyc  = i;
                break;
            end
            if (tog) CEN = ~CEN;
            @(posedge Clk); #1;
        end
        CEN = 1'b1;
        chk($sformatf("%s done", tag), {31'd0, done}, 32'd1);
        chk($sformatf("%s count", tag), got_q.size() - base, exp_q.size());
        chk($sformatf("%s starts", tag), n_start - sb, exp_q.size());
        chk($sformatf("%s acks", tag), n_ack - ab, exp_q.size());
        chk($sformatf("%s err", tag), {31'd0, Err}, 32'd0);
        chk($sformatf("%s busy", tag), {31'd0, Busy}, 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                chk($sformatf("%s r%0d a", tag, i), got_q[base+i].a, exp_q[i].a);
                chk($sformatf("%s r%0d b", tag, i), got_q[base+i].b, exp_q[i].b);
                chk($sformatf("%s r%0d gcd", tag, i), got_q[base+i].g, exp_q[i].g);
                chk($sformatf("%s r%0d clk", tag, i),
                    {31'd0, (got_q[base+i].c >= exp_q[i].c) && (got_q[base+i].c <= exp_q[i].c + 1)},
                    32'd1);
            end
        end
    endtask

    initial begin
        int  base_a, base_b, base_x, cyc, t_start, elapsed, ab, vb, lo, hi;
        bit  done;

        #2 Reset = 1'b0;
        #20;
        chk("rst start", {31'd0, core_if.Start}, 32'd0);
        chk("rst ack", {31'd0, core_if.Ack}, 32'd0);
        chk("rst busy", {31'd0, Busy}, 32'd0);
        chk("rst done", {31'd0, Sweep_Done}, 32'd0);
        chk("rst err", {31'd0, Err}, 32'd0);
        chk("rst valid", {31'd0, Res_Valid}, 32'd0);
        chk("rst ain", {24'd0, core_if.Ain}, 32'd0);
        chk("rst clocks", {16'd0, Res_Clocks}, 32'd0);
        Reset = 1'b1;
        CEN   = 1'b1;

        run_sweep(2, 3, 1'b0, "lo2hi3", base_a, cyc);
        chk("lo2hi3 sweep_done", {31'd0, Sweep_Done}, 32'd1);

        run_sweep(2, 3, 1'b1, "cen_tog", base_b, cyc);
        for (int i = 0; i < 4; i++) begin
            if (base_b + i < got_q.size()) begin
                chk($sformatf("cen_tog clk eq %0d", i), got_q[base_b+i].c, got_q[base_a+i].c);
            end
        end

        run_sweep(5, 4, 1'b0, "lo_gt_hi", base_x, cyc);
        chk("lo_gt_hi fast", {31'd0, (cyc >= 0) && (cyc < 3)}, 32'd1);

        run_sweep(255, 255, 1'b0, "max", base_x, cyc);
        chk("max ain hold", {24'd0, core_if.Ain}, 32'd255);
        chk("max bin hold", {24'd0, core_if.Bin}, 32'd255);

        for (int k = 0; k < 3; k++) begin
            lo = int'($urandom_range(1, 60));
            hi = lo + int'($urandom_range(0, 2));
            run_sweep(lo, hi, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k), base_x, cyc);
        end

        // Core that never finishes: the driver must give up on its own
        hang = 1'b1;
        ab   = n_ack;
        vb   = got_q.size();
        @(posedge Clk); #1;
        Lo = 8'd7; Hi = 8'd7; Go = 1'b1; CEN = 1'b1;
        @(posedge Clk); #1;
        Go      = 1'b0;
        t_start = -1;
        elapsed = -1;
        done    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (t_start < 0 && core_if.Start) t_start = i;
            if (Sweep_Done) begin
                done    = 1'b1;
                elapsed = i - t_start;
                break;
            end
            @(posedge Clk); #1;
        end
        chk("tmo done", {31'd0, done}, 32'd1);
        chk("tmo err", {31'd0, Err}, 32'd1);
        chk("tmo elapsed", {31'd0, (t_start >= 0) && (elapsed >= 15) && (elapsed <= 18)}, 32'd1);
        chk("tmo acks", n_ack - ab, 32'd0);
        chk("tmo results", got_q.size() - vb, 32'd0);
        hang  = 1'b0;
        Reset = 1'b0;
        #20 Reset = 1'b1;

        // Reset while the driver waits in WAIT_DONE
        @(posedge Clk); #1;
        Lo = 8'd2; Hi = 8'd3; Go = 1'b1;
        @(posedge Clk); #1;
        Go   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (core_if.q_Sub) begin
                done = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        chk("mid saw sub", {31'd0, done}, 32'd1);
        @(posedge Clk); #1;
        chk("mid busy", {31'd0, Busy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, Busy}, 32'd0);
        chk("mid rst start", {31'd0, core_if.Start}, 32'd0);
        chk("mid rst ack", {31'd0, core_if.Ack}, 32'd0);
        chk("mid rst ain", {24'd0, core_if.Ain}, 32'd0);
        chk("mid rst bin", {24'd0, core_if.Bin}, 32'd0);
        chk("mid rst res_a", {24'd0, Res_A}, 32'd0);
        chk("mid rst res_gcd", {24'd0, Res_GCD}, 32'd0);
        chk("mid rst done", {31'd0, Sweep_Done}, 32'd0);
        chk("mid rst err", {31'd0, Err}, 32'd0);
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        ab = n_ack;
        repeat (6) @(posedge Clk);
        #1;
        chk("post rst no ack", n_ack - ab, 32'd0);
        chk("post rst idle", {31'd0, Busy}, 32'd0);

        run_sweep(2, 3, 1'b0, "restart", base_x, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gcd_sweep_driver.md
GCD_SWEEP_DRIVER -- requirements
Module: gcd_sweep_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023; max Clk cycles allowed per WAIT_SUB plus WAIT_DONE before abort.
REQ-002 SHALL have port Clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port CEN  in  1  clock enable; no register, counter or state changes when 0.
REQ-005 SHALL have port Go  in  1  request to start a sweep, sampled in IDLE.
REQ-006 SHALL have ports Lo, Hi  in  8 each  inclusive sweep bounds, applied to both operands.
REQ-007 SHALL have ports Start, Ack  out  1 each  handshake pulses to the GCD core.
REQ-008 SHALL have ports Ain, Bin  out  8 each  operands presented to the GCD core.
REQ-009 SHALL have ports q_Sub, q_Done  in  1 each  GCD core state indicators.
REQ-010 SHALL have port AB_GCD  in  8  GCD core result.
REQ-011 SHALL have port Res_Valid  out  1  one-cycle result strobe.
REQ-012 SHALL have ports Res_A, Res_B, Res_GCD  out  8 each; Res_Clocks  out  16  held result record.
REQ-013 SHALL have ports Busy, Sweep_Done, Err  out  1 each  status flags.

Function
REQ-014 SHALL implement the states IDLE, LOAD, START, WAIT_SUB, WAIT_DONE, ACK, NEXT and FIN.
REQ-015 SHALL remain in IDLE, with Busy=0, until Go=1 and CEN=1 occur together; on that edge it latches Lo and Hi, sets Ain=Bin=Lo, clears Sweep_Done and Err, and enters LOAD.
REQ-016 SHALL go from IDLE directly to FIN when the latched Lo>Hi; no Start is issued and no result is produced.
REQ-017 SHALL hold Ain/Bin stable for one LOAD cycle, then assert Start for exactly one enabled cycle in START.
REQ-018 SHALL, in WAIT_SUB, zero the cycle counter and move to WAIT_DONE on the first cycle q_Sub=1.
REQ-019 SHALL, in WAIT_DONE, increment the counter each enabled cycle; on the first q_Done=1 it captures Ain, Bin, AB_GCD and the counter into Res_*, and enters ACK.
REQ-020 SHALL hold the 16-bit counter saturated at 16'hFFFF.
REQ-021 SHALL assert Ack for exactly one enabled cycle in ACK, pulse Res_Valid in that same cycle, and then enter NEXT.
REQ-022 SHALL step in NEXT as follows: if Bin<latched Hi, Bin+1; else if Ain<latched Hi, Ain+1 and Bin=Lo; else enter FIN.
REQ-023 SHALL compare before incrementing, so Hi=255 never wraps to 0.
REQ-024 SHALL otherwise return from NEXT to LOAD.
REQ-025 SHALL leave Start and Ack low in every state except START and ACK respectively.
REQ-026 SHALL, when WAIT_SUB plus WAIT_DONE exceeds TIMEOUT enabled cycles, set sticky Err and go to FIN without asserting Ack.
REQ-027 SHALL, in FIN, set Sweep_Done=1 and Busy=0, then return to IDLE on the next enabled cycle; Sweep_Done and Err persist until the next accepted Go.
REQ-028 SHALL drive Busy=1 in all states other than IDLE and FIN.
REQ-029 SHALL ignore Go outside IDLE.
REQ-030 SHALL suspend a Start or Ack cycle while CEN=0, keeping the pulse asserted but uncounted until the next enabled edge.

Reset
REQ-031 SHALL, while Reset=0, asynchronously force state IDLE.
REQ-032 SHALL, while Reset=0, clear Start, Ack, Res_Valid, Busy, Sweep_Done and Err.
REQ-033 SHALL, while Reset=0, set Ain, Bin, Res_A, Res_B, Res_GCD and the latched bounds to 8'h00, and Res_Clocks and the counter to 16'h0000.
REQ-034 SHALL abort any sweep on reset mid-operation, with no Ack issued afterwards.

Structure
REQ-035 SHALL place the state encoding (3-bit localparams) and the counter width in a shared package, gcd_sweep_pkg.
REQ-036 SHALL contain one sub-module, gcd_op_stepper, holding the Ain/Bin registers and the NEXT/last-pair compare logic.

Verification
REQ-037 SHALL cover Lo=2, Hi=3 with a behavioural GCD core: exactly 4 Res_Valid pulses, in order (2,2,2), (2,3,1), (3,2,1), (3,3,3), then Sweep_Done=1.
REQ-038 SHALL cover Lo=5, Hi=4: Sweep_Done=1 within 3 cycles, with zero Start pulses and zero Res_Valid pulses.
REQ-039 SHALL cover Lo=Hi=255: one result, (255,255,255), and no wrap to 0.
REQ-040 SHALL cover a core that never raises q_Done with TIMEOUT=15: Err=1 and Sweep_Done=1 about 16 cycles after Start, and Ack never asserted.
REQ-041 SHALL cover CEN toggling 1/0 every cycle during Lo=2, Hi=3: the same four results as REQ-037, with Res_Clocks equal to the CEN=1 run.
REQ-042 SHALL cover Reset=0 asserted in WAIT_DONE: immediate IDLE and all outputs at reset values; a following Go restarts from Lo.
